serial_frame_rx: RTL and testbench

SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

---
 rtl/serial_frame_rx.sv | 123 ++++++++++++
 tb/tb_serial_frame_rx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, DW data bits LSB first, optional even parity, stop bit.
// Latency: data/valid update on the edge that samples the stop bit.
// Backpressure: a held unaccepted frame blocks new loads; a newer good frame is dropped and overrun pulses.
module serial_frame_rx #(
  parameter int DW        = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          si,
  input  logic          ready,
  output logic [DW-1:0] data,
  output logic          valid,
  output logic          parity_err,
  output logic          frame_err,
  output logic          overrun
);

  // Counter only has to reach DW-1; keep at least one bit for DW=1.
  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [DW-1:0] shreg;
  logic          par_bit;
  logic          last_bit;
  logic          load;
  logic          drop;
  logic          ferr;
  logic          rx_perr;

  assign last_bit = (cnt == CW'(DW - 1));

  // Even parity: data bits XOR received parity bit must be 0.
  assign rx_perr = PARITY_EN ? ((^shreg) ^ par_bit) : 1'b0;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and stop-bit decisions (load, drop on overrun, framing error).
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    drop      = 1'b0;
    ferr      = 1'b0;
    case (state)
      IDLE: begin
        if (!si) state_nxt = DATA;
      end
      DATA: begin
        if (last_bit) state_nxt = PARITY_EN ? PARITY : STOP;
      end
      PARITY: begin
        state_nxt = STOP;
      end
      STOP: begin
        state_nxt = IDLE;
        if (si) begin
          if (!valid || ready) load = 1'b1;
          else                 drop = 1'b1;
        end else begin
          ferr = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bit counter: cleared while idle, advances once per captured data bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (state == IDLE)  cnt <= '0;
    else if (state == DATA)  cnt <= cnt + CW'(1);
  end

  // Capture data bits at the counter position and the parity bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      if (state == DATA) begin
        for (int i = 0; i < DW; i++) begin
          if (cnt == CW'(i)) shreg[i] <= si;
        end
      end
      if (state == PARITY) par_bit <= si;
    end
  end

  // Output holding register with valid/ready handshake; a load on the
  // accepting edge keeps valid high with the new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
    end else if (load) begin
      data       <= shreg;
      parity_err <= rx_perr;
      valid      <= 1'b1;
    end else if (valid && ready) begin
      valid      <= 1'b0;
    end
  end

  // One-cycle status pulses for the frame that just ended.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr;
      overrun   <= drop;
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Testbench for serial_frame_rx (DW=8, even parity).
module tb_serial_frame_rx;

  logic       clk;
  logic       rst_n;
  logic       si;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;

  serial_frame_rx #(.DW(8), .PARITY_EN(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .si         (si),
    .ready      (ready),
    .data       (data),
    .valid      (valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc      = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  logic [7:0] last_data = 8'h00;

  logic [8:0] exp_q[$];   // {parity_err, data}
  int         xfer_q[$];  // cycle of each accepted transfer

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor / scoreboard: sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err) fe_cnt++;
      if (overrun)   ov_cnt++;
      if (valid && ready) begin
        xfer_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_xfer", {23'd0, parity_err, data}, 32'h1ff);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          chk("xfer_data", {24'd0, data}, {24'd0, e[7:0]});
          chk("xfer_perr", {31'd0, parity_err}, {31'd0, e[8]});
          last_data = data;
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    si = b;
    @(posedge clk);
    #1;
  endtask

  // Sends one frame; the expected delivery is queued when the frame is a good one.
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop, input bit push);
    logic p;
    p = (^d) ^ bad_par;
    if (push) exp_q.push_back({bad_par, d});
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(stop);
    si = 1'b1;
  endtask

  task automatic idle(input int n);
    si = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] d;
    bit         bad_par;
    bit         stop;
    bit         deliver;
    int         exp_fe;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe0, ov0;
    vecs[0] = '{d: 8'hA5, bad_par: 1'b0, stop: 1'b1, deliver: 1'b1, exp_fe: 0};
    vecs[1] = '{d: 8'h01, bad_par: 1'b1, stop: 1'b1, deliver: 1'b1, exp_fe: 0};
    vecs[2] = '{d: 8'h3C, bad_par: 1'b0, stop: 1'b0, deliver: 1'b0, exp_fe: 1};
    vecs[3] = '{d: 8'hFF, bad_par: 1'b0, stop: 1'b1, deliver: 1'b1, exp_fe: 0};
    vecs[4] = '{d: 8'h00, bad_par: 1'b1, stop: 1'b1, deliver: 1'b1, exp_fe: 0};

    rst_n = 1'b0;
    si    = 1'b1;
    ready = 1'b1;
    #12;
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_data", {24'd0, data}, 32'd0);
    chk("rst_perr", {31'd0, parity_err}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // 0xA5: valid exactly after the stop-bit edge, clears one edge later.
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("lat_valid", {31'd0, valid}, 32'd1);
    chk("lat_data", {24'd0, data}, 32'hA5);
    chk("lat_perr", {31'd0, parity_err}, 32'd0);
    @(negedge clk);
    chk("lat_clear", {31'd0, valid}, 32'd0);
    idle(2);

    // Table-driven frames with ready held high.
    for (int k = 0; k < 5; k++) begin
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      send_frame(vecs[k].d, vecs[k].bad_par, vecs[k].stop, vecs[k].deliver);
      idle(3);
      chk("vec_ferr", fe_cnt - fe0, vecs[k].exp_fe);
      chk("vec_ovr", ov_cnt - ov0, 32'd0);
      chk("vec_drained", exp_q.size(), 32'd0);
      if (!vecs[k].deliver) begin
        chk("vec_hold_data", {24'd0, data}, {24'd0, last_data});
        chk("vec_no_valid", {31'd0, valid}, 32'd0);
      end
    end

    // Overrun: ready low, two back-to-back frames; only the first is kept.
    ready = 1'b0;
    ov0 = ov_cnt;
    fe0 = fe_cnt;
    send_frame(8'h11, 1'b0, 1'b1, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0);
    idle(3);
    chk("ovr_pulse", ov_cnt - ov0, 32'd1);
    chk("ovr_no_ferr", fe_cnt - fe0, 32'd0);
    chk("ovr_hold_valid", {31'd0, valid}, 32'd1);
    chk("ovr_hold_data", {24'd0, data}, 32'h11);
    ready = 1'b1;
    idle(3);
    chk("ovr_drained_valid", {31'd0, valid}, 32'd0);
    chk("ovr_drained_q", exp_q.size(), 32'd0);

    // Back-to-back with ready high: two transfers 11 edges apart.
    xfer_q.delete();
    ov0 = ov_cnt;
    send_frame(8'h55, 1'b0, 1'b1, 1'b1);
    send_frame(8'hAA, 1'b0, 1'b1, 1'b1);
    idle(3);
    chk("b2b_count", xfer_q.size(), 32'd2);
    if (xfer_q.size() == 2) chk("b2b_gap", xfer_q[1] - xfer_q[0], 32'd11);
    chk("b2b_no_ovr", ov_cnt - ov0, 32'd0);

    // Reset mid-frame, then a frame starting on the first edge after release.
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    rst_n = 1'b0;
    si    = 1'b1;
    #2;
    chk("midrst_data", {24'd0, data}, 32'd0);
    chk("midrst_valid", {31'd0, valid}, 32'd0);
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    send_frame(8'h7E, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("rst_start_valid", {31'd0, valid}, 32'd1);
    chk("rst_start_data", {24'd0, data}, 32'h7E);
    idle(3);
    chk("midrst_ferr", fe_cnt - fe0, 32'd0);
    chk("midrst_ovr", ov_cnt - ov0, 32'd0);
    chk("final_q_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
